// File: rtl/ticket_payment.sv
// ----------------------------------------------------------------------------
// ticket_payment : coin-operated ticket sale FSM with change / refund dispense
// Optional: define PAYMENT_TIMEOUT_EN for the COLLECT inactivity timeout.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ticket_payment #(
  parameter int PRICE          = 15,
  parameter int MAX_TICKETS    = 18,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] qty,
  input  logic       coin_valid,
  input  logic [1:0] coin_code,
  input  logic       cancel,
  input  logic       change_ack,
  output logic       busy,
  output logic [9:0] amount_due,
  output logic [9:0] amount_paid,
  output logic       change_valid,
  output logic [1:0] change_coin,
  output logic       done,
  output logic       refunded
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CHANGE  = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  localparam logic [9:0]  C_PRICE = 10'(PRICE);
  localparam logic [31:0] C_MAX   = 32'(MAX_TICKETS);

  state_t     state_q, state_d;
  logic [9:0] due_q, due_d;
  logic [9:0] paid_q, paid_d;
  logic [9:0] rem_q, rem_d;
  logic       refund_q, refund_d;

  logic [9:0] w_total;
  logic [1:0] w_coin;
  logic       w_timeout;
  logic       w_abort;

  function automatic logic [9:0] coin_value(input logic [1:0] code);
    logic [9:0] v;
    case (code)
      2'b00:   v = 10'd5;
      2'b01:   v = 10'd10;
      2'b10:   v = 10'd20;
      default: v = 10'd50;
    endcase
    return v;
  endfunction

`ifdef PAYMENT_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // Counter is zero outside COLLECT, so entry into COLLECT restarts it.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_COLLECT && !coin_valid) begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  assign w_timeout = (state_q == S_COLLECT) && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign w_abort = cancel | w_timeout;
  assign w_total = paid_q + coin_value(coin_code);

  // Greedy change selection: largest coin that still fits.
  always_comb begin
    w_coin = 2'b00;
    if (rem_q >= 10'd50)      w_coin = 2'b11;
    else if (rem_q >= 10'd20) w_coin = 2'b10;
    else if (rem_q >= 10'd10) w_coin = 2'b01;
  end

  always_comb begin
    state_d  = state_q;
    due_d    = due_q;
    paid_d   = paid_q;
    rem_d    = rem_q;
    refund_d = refund_q;
    case (state_q)
      S_IDLE: begin
        if (start && qty != 5'd0 && 32'(qty) <= C_MAX) begin
          due_d   = {5'd0, qty} * C_PRICE;
          paid_d  = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_abort) begin
          refund_d = 1'b1;
          rem_d    = paid_q;
          state_d  = (paid_q != 10'd0) ? S_CHANGE : S_FINISH;
        end else if (coin_valid) begin
          paid_d   = w_total;
          refund_d = 1'b0;
          if (w_total == due_q) begin
            state_d = S_FINISH;
          end else if (w_total > due_q) begin
            rem_d   = w_total - due_q;
            state_d = S_CHANGE;
          end
        end
      end
      S_CHANGE: begin
        if (change_ack) begin
          rem_d = rem_q - coin_value(w_coin);
          if (rem_d == 10'd0) state_d = S_FINISH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      due_q    <= '0;
      paid_q   <= '0;
      rem_q    <= '0;
      refund_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      due_q    <= due_d;
      paid_q   <= paid_d;
      rem_q    <= rem_d;
      refund_q <= refund_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign amount_due   = due_q;
  assign amount_paid  = paid_q;
  assign change_valid = (state_q == S_CHANGE);
  assign change_coin  = w_coin;
  assign done         = (state_q == S_FINISH) && !refund_q;
  assign refunded     = (state_q == S_FINISH) && refund_q;

endmodule

`default_nettype wire

// File: tb/tb_ticket_payment.sv
// ----------------------------------------------------------------------------
// tb_ticket_payment : randomized scoreboard bench for ticket_payment
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ticket_payment;

  logic       clk = 1'b0;
  logic       rst, start, coin_valid, cancel, change_ack;
  logic [4:0] qty;
  logic [1:0] coin_code;
  logic       busy, change_valid, done, refunded;
  logic [9:0] amount_due, amount_paid;
  logic [1:0] change_coin;

  ticket_payment dut (
    .clk(clk), .rst(rst), .start(start), .qty(qty),
    .coin_valid(coin_valid), .coin_code(coin_code), .cancel(cancel),
    .change_ack(change_ack), .busy(busy), .amount_due(amount_due),
    .amount_paid(amount_paid), .change_valid(change_valid),
    .change_coin(change_coin), .done(done), .refunded(refunded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sb[$];          // expected events: 0..3 change coin code, 4 done, 5 refunded
  int ack_mode = 0;   // 0 random, 1 always, 2 never, 3 after 5 presented cycles
  int vcnt     = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input string name, input int act);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: unexpected event %0d with empty scoreboard at %0t", name, act, $time);
    end else begin
      check(name, act, sb.pop_front());
    end
  endtask

  function automatic int cv(input int c);
    return (c == 0) ? 5 : (c == 1) ? 10 : (c == 2) ? 20 : 50;
  endfunction

  // Expected change/refund coin stream for an amount.
  task automatic push_greedy(input int amt);
    int r = amt;
    while (r > 0) begin
      if (r >= 50)      begin sb.push_back(3); r -= 50; end
      else if (r >= 20) begin sb.push_back(2); r -= 20; end
      else if (r >= 10) begin sb.push_back(1); r -= 10; end
      else              begin sb.push_back(0); r -= 5;  end
    end
  endtask

  // Dispenser model
  initial begin
    change_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (change_valid) vcnt++;
      else              vcnt = 0;
      case (ack_mode)
        0:       change_ack = 1'($urandom_range(0, 1));
        1:       change_ack = 1'b1;
        2:       change_ack = 1'b0;
        default: change_ack = (vcnt > 5);
      endcase
      if (change_ack && change_valid) vcnt = 0;
    end
  end

  // Monitor
  initial begin
    bit pv = 0, pa = 0;
    int pc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
      end else begin
        if (change_valid && pv && !pa) check("coin_stable", change_coin, pc);
        if (change_valid && change_ack) pop_cmp("change_coin", change_coin);
        if (done)     pop_cmp("done_evt", 4);
        if (refunded) pop_cmp("refund_evt", 5);
        if (done && refunded) check("done_and_refunded", 1, 0);
        pv = change_valid;
        pa = change_ack;
        pc = change_coin;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_txn(input int q, input int coins[$], input int cancel_after,
                        input int cancel_coin, input bit wait_done);
    int due = q * 15;
    int paid = 0;
    int k = 0;
    int c;
    int t;
    bit fin = 0;
    @(posedge clk); #1;
    start = 1'b1; qty = 5'(q);
    @(posedge clk); #1;
    start = 1'b0;
    check("amount_due_latched", amount_due, due);
    check("amount_paid_cleared", amount_paid, 0);
    check("busy_collect", busy, 1);
    while (!fin) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if (cancel_after >= 0 && k == cancel_after) begin
        cancel = 1'b1;
        coin_valid = (cancel_coin >= 0);
        coin_code = 2'(cancel_coin);
        @(posedge clk); #1;
        cancel = 1'b0; coin_valid = 1'b0;
        push_greedy(paid);
        sb.push_back(5);
        fin = 1;
      end else begin
        c = (coins.size() > 0) ? coins.pop_front() : int'($urandom_range(0, 3));
        coin_valid = 1'b1; coin_code = 2'(c);
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1; qty = 5'($urandom_range(1, 18));
        end
        @(posedge clk); #1;
        coin_valid = 1'b0; start = 1'b0;
        paid += cv(c);
        k++;
        if (paid >= due) begin
          push_greedy(paid - due);
          sb.push_back(4);
          fin = 1;
        end
      end
    end
    if (wait_done) begin
      t = 0;
      while (busy === 1'b1 && t < 400) begin @(negedge clk); t++; end
      check("busy_released", busy, 0);
      check("amount_paid_held", amount_paid, paid);
      check("amount_due_held", amount_due, due);
    end
  endtask

  initial begin
    int cl[$];
    int q, ca, cc;
    rst = 1'b1; start = 1'b0; qty = '0; coin_valid = 1'b0; coin_code = '0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_due", amount_due, 0);
    check("rst_paid", amount_paid, 0);
    check("rst_change_valid", change_valid, 0);
    check("rst_change_coin", change_coin, 0);
    check("rst_done", done, 0);
    check("rst_refunded", refunded, 0);
    rst = 1'b0;

    // Illegal quantities are ignored
    foreach (cl[i]) cl.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 1'b1; qty = (i == 0) ? 5'd0 : (i == 1) ? 5'd19 : 5'd31;
      @(posedge clk); #1;
      start = 1'b0;
      check("bad_qty_busy", busy, 0);
      @(negedge clk);
      check("bad_qty_busy_later", busy, 0);
    end

    // qty 2, coins 10 + 20: exact payment
    cl.delete(); cl.push_back(1); cl.push_back(2);
    do_txn(2, cl, -1, -1, 1);

    // qty 1, coin 50, dispenser always ready: change 20, 10, 5
    ack_mode = 1;
    cl.delete(); cl.push_back(3);
    do_txn(1, cl, -1, -1, 1);

    // qty 3, coin 20, cancel with a 50 in the same cycle
    ack_mode = 0;
    cl.delete(); cl.push_back(2);
    do_txn(3, cl, 1, 3, 1);

    // qty 1, coin 20, dispenser acknowledges late
    ack_mode = 3;
    cl.delete(); cl.push_back(2);
    do_txn(1, cl, -1, -1, 1);

    // Cancel before any coin
    ack_mode = 0;
    cl.delete();
    do_txn(5, cl, 0, -1, 1);

    // Coin while idle is ignored
    @(posedge clk); #1;
    coin_valid = 1'b1; coin_code = 2'b11;
    @(posedge clk); #1;
    coin_valid = 1'b0;
    check("idle_coin_paid", amount_paid, 0);
    check("idle_coin_busy", busy, 0);

    // Reset while change is pending
    ack_mode = 2;
    cl.delete(); cl.push_back(3);
    do_txn(1, cl, -1, -1, 0);
    repeat (3) @(negedge clk);
    check("change_pending", change_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midchg_rst_busy", busy, 0);
    check("midchg_rst_due", amount_due, 0);
    check("midchg_rst_paid", amount_paid, 0);
    check("midchg_rst_cv", change_valid, 0);
    check("midchg_rst_coin", change_coin, 0);
    check("midchg_rst_done", done, 0);
    check("midchg_rst_ref", refunded, 0);
    sb.delete();
    rst = 1'b0;
    ack_mode = 0;

    // Randomized sales
    for (int n = 0; n < 40; n++) begin
      q  = $urandom_range(1, 18);
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      cc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : -1;
      ack_mode = ($urandom_range(0, 5) == 0) ? 3 : int'($urandom_range(0, 1));
      cl.delete();
      do_txn(q, cl, ca, cc, 1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ticket_payment.md
TICKET_PAYMENT -- requirements
Module: ticket_payment

Interface
REQ-001 Parameter PRICE, default 15: price of one ticket in currency units.
REQ-002 Parameter MAX_TICKETS, default 18: largest accepted ticket quantity (one per seat switch).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000000: inactivity limit in clock cycles; used only under PAYMENT_TIMEOUT_EN.
REQ-004 The block SHALL use one clock, clk; reset is synchronous and active-high, named rst.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle request to begin a payment for qty tickets.
REQ-008 qty  input  5  ticket quantity, sampled when start is high.
REQ-009 coin_valid  input  1  single-cycle pulse; one coin has been inserted.
REQ-010 coin_code  input  2  inserted coin value: 00=5, 01=10, 10=20, 11=50.
REQ-011 cancel  input  1  single-cycle request to abort and refund.
REQ-012 change_ack  input  1  dispenser has accepted the presented change coin.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 amount_due  output  10  registered value of qty*PRICE.
REQ-015 amount_paid  output  10  running coin total.
REQ-016 change_valid  output  1  a change or refund coin is being presented.
REQ-017 change_coin  output  2  presented coin value, same encoding as coin_code.
REQ-018 done  output  1  one-cycle pulse: sale completed.
REQ-019 refunded  output  1  one-cycle pulse: sale aborted and fully refunded.

Function
REQ-020 The FSM SHALL have the states IDLE, COLLECT, CHANGE and FINISH.
REQ-021 In IDLE, start with 1<=qty<=MAX_TICKETS SHALL latch amount_due=qty*PRICE, clear amount_paid and enter COLLECT on the next cycle.
- start with qty=0 or qty>MAX_TICKETS is ignored.
- start outside IDLE is ignored.
REQ-022 In COLLECT, coin_valid SHALL add the coin value to amount_paid, visible the next cycle.
- Coins are ignored in all other states.
REQ-023 After a coin is added, the comparison SHALL use the new total, with the state change in the same cycle amount_paid updates:
- new total == due: enter FINISH, done flag.
- new total > due: load remaining = total - due and enter CHANGE, done flag.
- new total < due: stay in COLLECT.
REQ-024 cancel in COLLECT SHALL take priority over a coin in the same cycle; that coin is discarded.
- If amount_paid > 0: remaining = amount_paid, enter CHANGE, refund flag.
- If amount_paid = 0: enter FINISH, refund flag.
REQ-025 In CHANGE, the block SHALL present the largest coin not exceeding remaining, checked in the order 50, 20, 10, 5.
- change_valid=1; change_coin is held stable until change_ack.
REQ-026 On change_valid && change_ack, remaining SHALL decrease by the coin value.
- Next coin is presented the following cycle; change_valid may stay high.
- When remaining reaches 0: enter FINISH, deassert change_valid.
REQ-027 change_ack while change_valid=0 SHALL be ignored.
REQ-028 FINISH SHALL last exactly one cycle, pulsing done or refunded according to the flag, then return to IDLE.
- amount_due and amount_paid are held until the next accepted start.
REQ-029 All arithmetic SHALL be 10-bit unsigned.
- Worst case total is 270-5+50=315, so no overflow.
- remaining is always a multiple of 5.

Reset
REQ-030 rst SHALL force state=IDLE and clear remaining and all flags in any state, including mid-CHANGE.
REQ-031 Reset values: busy=0, amount_due=0, amount_paid=0, change_valid=0, change_coin=00, done=0, refunded=0.

Configuration
REQ-032 With PAYMENT_TIMEOUT_EN defined, a cycle counter SHALL run in COLLECT.
- The counter restarts on entry to COLLECT and on each accepted coin.
- On reaching TIMEOUT_CYCLES, the block behaves exactly as cancel (REQ-024).
REQ-033 Without PAYMENT_TIMEOUT_EN, no counter is built, TIMEOUT_CYCLES is unused, and COLLECT waits indefinitely.

Verification
REQ-034 qty=2, coins 10 then 20 -> amount_due=30, amount_paid=30, no change_valid, single done pulse, then busy=0.
REQ-035 qty=1, coin 50, change_ack tied high -> change_coin sequence 20, 10, 5, then done.
REQ-036 qty=3, coin 20, then cancel asserted in the same cycle as a coin 50 -> 50 discarded, single refund coin 20, refunded pulse, no done.
REQ-037 qty=1, coin 20, change_ack delayed 5 cycles -> change_valid=1 and change_coin=00 stable for all 5 cycles, then done.
REQ-038 start with qty=0 and with qty=19 -> busy stays 0; rst asserted mid-CHANGE -> all outputs at reset values the next cycle.
REQ-039 PAYMENT_TIMEOUT_EN with TIMEOUT_CYCLES=100, qty=1, coin 5, then 100 idle cycles -> refund coin 5, refunded pulse.
